// File: rtl/activation_unit.sv
// Single-neuron activation engine: accumulates N_TERMS float32 products theta*x
// and emits (S/(1+|S|)+1)/2, with one FSM sequencing mul, add and an iterative divider.
module activation_unit #(
  parameter int N_TERMS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_theta,
  input  logic [31:0] input_x,
  input  logic        input_theta_stb,
  input  logic        input_x_stb,
  input  logic        output_activation_ack,
  output logic [31:0] activation,
  output logic        output_activation_stb,
  output logic        bringInNextSetofInput
);

  localparam int CW = $clog2(N_TERMS + 1);
  localparam logic [31:0] ONE = 32'h3F800000;

  typedef enum logic [3:0] {
    ST_GET, ST_MUL, ST_ADD, ST_REQ, ST_WAIT,
    ST_SIG_D, ST_SIG_DIV, ST_SIG_C, ST_SIG_A, ST_OUT
  } state_t;

  state_t          state, next_state;
  logic [31:0]     theta_r, x_r, prod, acc, d_reg, c_reg;
  logic [CW-1:0]   count, count_inc;
  logic [24:0]     rem;
  logic [27:0]     quo;
  logic [4:0]      div_cnt;

  // NaN/Inf read as max finite, denormals read as zero.
  function automatic logic [23:0] mant_of(input logic [31:0] f);
    if (f[30:23] == 8'hFF)      mant_of = 24'hFFFFFF;
    else if (f[30:23] == 8'h00) mant_of = 24'h000000;
    else                        mant_of = {1'b1, f[22:0]};
  endfunction

  function automatic logic signed [9:0] exp_of(input logic [31:0] f);
    if (f[30:23] == 8'hFF)      exp_of = 10'sd254;
    else if (f[30:23] == 8'h00) exp_of = 10'sd0;
    else                        exp_of = $signed({2'b00, f[30:23]});
  endfunction

  // m holds a normalized 24-bit mantissa followed by guard, round and sticky bits.
  function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                             input logic [26:0] m);
    logic [24:0]       r;
    logic signed [9:0] ex;
    logic              up;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    ex = e;
    if (r[24]) begin
      r  = r >> 1;
      ex = ex + 10'sd1;
    end
    if (ex >= 10'sd255)    round_pack = {s, 8'hFE, 23'h7FFFFF};
    else if (ex <= 10'sd0) round_pack = {s, 31'd0};
    else                   round_pack = {s, ex[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    p = {24'd0, mant_of(a)} * {24'd0, mant_of(b)};
    e = exp_of(a) + exp_of(b) - 10'sd127;
    if (p == 48'd0)  fmul = {a[31] ^ b[31], 31'd0};
    else if (p[47])  fmul = round_pack(a[31] ^ b[31], e + 10'sd1, {p[47:22], |p[21:0]});
    else             fmul = round_pack(a[31] ^ b[31], e, {p[46:21], |p[20:0]});
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       hi, lo;
    logic signed [9:0] e;
    logic [9:0]        sh;
    logic [26:0]       mh, ml, ml_sh, m;
    logic [27:0]       sum;
    if ({exp_of(a), mant_of(a)} < {exp_of(b), mant_of(b)}) begin
      hi = b;
      lo = a;
    end else begin
      hi = a;
      lo = b;
    end
    mh = {mant_of(hi), 3'b000};
    ml = {mant_of(lo), 3'b000};
    e  = exp_of(hi);
    sh = 10'(exp_of(hi) - exp_of(lo));
    if (sh > 10'd26) ml_sh = {26'd0, |ml};
    else             ml_sh = (ml >> sh) | {26'd0, |(ml & ((27'd1 << sh) - 27'd1))};
    if (hi[31] == lo[31]) sum = {1'b0, mh} + {1'b0, ml_sh};
    else                  sum = {1'b0, mh} - {1'b0, ml_sh};
    m = sum[26:0];
    if (sum == 28'd0) fadd = 32'd0;
    else if (sum[27]) fadd = round_pack(hi[31], e + 10'sd1, {sum[27:2], |sum[1:0]});
    else begin
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 10'sd1;
        end
      end
      fadd = round_pack(hi[31], e, m);
    end
  endfunction

  // Halving by exponent decrement; anything that would go denormal flushes to zero.
  function automatic logic [31:0] halve(input logic [31:0] f);
    if (f[30:23] <= 8'd1) halve = {f[31], 31'd0};
    else                  halve = {f[31], f[30:23] - 8'd1, f[22:0]};
  endfunction

  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_GET;
    else     state <= next_state;
  end

  always_comb begin
    next_state            = state;
    bringInNextSetofInput = 1'b0;
    case (state)
      ST_GET:     if (input_theta_stb && input_x_stb) next_state = ST_MUL;
      ST_MUL:     next_state = ST_ADD;
      ST_ADD:     next_state = (count_inc < CW'(N_TERMS)) ? ST_REQ : ST_SIG_D;
      ST_REQ: begin
        bringInNextSetofInput = 1'b1;
        next_state            = ST_WAIT;
      end
      ST_WAIT:    next_state = ST_GET;
      ST_SIG_D:   next_state = ST_SIG_DIV;
      ST_SIG_DIV: if (div_cnt == 5'd27) next_state = ST_SIG_C;
      ST_SIG_C:   next_state = ST_SIG_A;
      ST_SIG_A:   next_state = ST_OUT;
      ST_OUT:     if (output_activation_ack) next_state = ST_REQ;
      default:    next_state = ST_GET;
    endcase
  end

  // Restoring division runs 28 steps so the quotient keeps 24 bits plus guard/round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_r               <= '0;
      x_r                   <= '0;
      prod                  <= '0;
      acc                   <= '0;
      count                 <= '0;
      d_reg                 <= '0;
      c_reg                 <= '0;
      rem                   <= '0;
      quo                   <= '0;
      div_cnt               <= '0;
      activation            <= '0;
      output_activation_stb <= 1'b0;
    end else begin
      case (state)
        ST_GET: if (input_theta_stb && input_x_stb) begin
          theta_r <= input_theta;
          x_r     <= input_x;
        end
        ST_MUL: prod <= fmul(theta_r, x_r);
        ST_ADD: begin
          acc   <= fadd(acc, prod);
          count <= count_inc;
        end
        ST_SIG_D: begin
          d_reg   <= fadd(ONE, {1'b0, acc[30:0]});
          rem     <= {1'b0, mant_of(acc)};
          quo     <= '0;
          div_cnt <= '0;
        end
        ST_SIG_DIV: begin
          if (rem >= {1'b0, mant_of(d_reg)}) begin
            rem <= (rem - {1'b0, mant_of(d_reg)}) << 1;
            quo <= {quo[26:0], 1'b1};
          end else begin
            rem <= rem << 1;
            quo <= {quo[26:0], 1'b0};
          end
          div_cnt <= div_cnt + 5'd1;
        end
        ST_SIG_C: begin
          if (mant_of(acc) == 24'd0)
            c_reg <= 32'd0;
          else if (quo[27])
            c_reg <= round_pack(acc[31], exp_of(acc) - exp_of(d_reg) + 10'sd127,
                                {quo[27:2], (|quo[1:0]) | (|rem)});
          else
            c_reg <= round_pack(acc[31], exp_of(acc) - exp_of(d_reg) + 10'sd126,
                                {quo[26:1], quo[0] | (|rem)});
        end
        ST_SIG_A: begin
          activation            <= halve(fadd(c_reg, ONE));
          output_activation_stb <= 1'b1;
        end
        ST_OUT: if (output_activation_ack) begin
          output_activation_stb <= 1'b0;
          acc                   <= '0;
          count                 <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed scenarios plus random sets
// compared against a real-valued model of (S/(1+|S|)+1)/2.
module tb_activation_unit;

  localparam int N = 3;
  localparam logic [31:0] REF_ACT = 32'h3F32A1D3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_theta, input_x;
  logic        input_theta_stb, input_x_stb, output_activation_ack;
  logic [31:0] activation;
  logic        output_activation_stb, bringInNextSetofInput;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] set_theta [N];
  logic [31:0] set_x [N];

  activation_unit #(.N_TERMS(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .input_theta           (input_theta),
    .input_x               (input_x),
    .input_theta_stb       (input_theta_stb),
    .input_x_stb           (input_x_stb),
    .output_activation_ack (output_activation_ack),
    .activation            (activation),
    .output_activation_stb (output_activation_stb),
    .bringInNextSetofInput (bringInNextSetofInput)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  // Exact-real reference: dot product then the soft sigmoid.
  function automatic real model_act();
    real s = 0.0;
    for (int i = 0; i < N; i++) s += f2r(set_theta[i]) * f2r(set_x[i]);
    return (s / (1.0 + ((s < 0.0) ? -s : s)) + 1.0) / 2.0;
  endfunction

  task automatic load_reference();
    set_theta[0] = 32'h3F000000; set_x[0] = 32'h3F2AAAAB;
    set_theta[1] = 32'h3EDC28F6; set_x[1] = 32'h3E800000;
    set_theta[2] = 32'h3F3645A2; set_x[2] = 32'h3E99999A;
  endtask

  // Drives one full set, reloading operands on each request pulse.
  task automatic run_set(input int stall_cycles, output logic [31:0] result, output int pulses);
    int idx = 0;
    int budget = 0;
    int since_last = 0;
    bit done = 0;
    pulses = 0;
    result = '0;
    input_theta = set_theta[0];
    input_x = set_x[0];
    input_theta_stb = 1'b1;
    input_x_stb = 1'b1;
    while (!done && budget < 400) begin
      step();
      budget++;
      if (idx == N - 1) since_last++;
      if (bringInNextSetofInput) begin
        pulses++;
        if (idx < N - 1) idx++;
        input_theta = set_theta[idx];
        input_x = set_x[idx];
        if (stall_cycles > 0 && pulses == 1) begin
          input_x_stb = 1'b0;
          for (int k = 0; k < stall_cycles; k++) begin
            input_theta_stb = k[0];
            step();
            budget++;
            vectors++;
            if (bringInNextSetofInput || output_activation_stb) begin
              miscompares++;
              $display("[TB] FAIL stall_idle: pulse=%0b stb=%0b required 0/0", bringInNextSetofInput, output_activation_stb);
            end
          end
          input_theta_stb = 1'b1;
          input_x_stb = 1'b1;
        end
      end
      if (output_activation_stb) begin
        done = 1;
        result = activation;
      end
    end
    input_theta_stb = 1'b0;
    input_x_stb = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL set_timeout: no output_activation_stb within %0d cycles", budget);
    end
    vectors++;
    if (pulses != N - 1) begin
      miscompares++;
      $display("[TB] FAIL request_pulses: got %0d required %0d", pulses, N - 1);
    end
    vectors++;
    if (since_last > 123) begin
      miscompares++;
      $display("[TB] FAIL latency: got %0d cycles required <= 123", since_last);
    end
  endtask

  task automatic release_result();
    output_activation_ack = 1'b1;
    step();
    output_activation_ack = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    input_theta = '0; input_x = '0;
    input_theta_stb = 1'b0; input_x_stb = 1'b0; output_activation_ack = 1'b0;
    step(); step();
    vectors++;
    if (activation !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_activation: got %h required 00000000", activation); end
    vectors++;
    if (output_activation_stb !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stb: got %b required 0", output_activation_stb); end
    vectors++;
    if (bringInNextSetofInput !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pulse: got %b required 0", bringInNextSetofInput); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reference();
    logic [31:0] res;
    int p, diff;
    load_reference();
    run_set(0, res, p);
    diff = int'(res) - int'(REF_ACT);
    vectors++;
    if (diff > 2 || diff < -2) begin
      miscompares++;
      $display("[TB] FAIL reference_activation: got %h required %h +-2 ULP", res, REF_ACT);
    end
  endtask

  // Runs with the reference result still presented.
  task automatic test_hold_ack();
    logic [31:0] first;
    int diff;
    first = activation;
    output_activation_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      diff = int'(activation) - int'(REF_ACT);
      vectors++;
      if (output_activation_stb !== 1'b1 || activation !== first || diff > 2 || diff < -2 || bringInNextSetofInput !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_stable: cycle %0d act=%h stb=%b pulse=%b required act=%h stb=1 pulse=0", i, activation, output_activation_stb, bringInNextSetofInput, first);
      end
    end
    output_activation_ack = 1'b1;
    step();
    output_activation_ack = 1'b0;
    vectors++;
    if (output_activation_stb !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_stb_drop: got %b required 0", output_activation_stb); end
    vectors++;
    if (bringInNextSetofInput !== 1'b1) begin miscompares++; $display("[TB] FAIL ack_pulse: got %b required 1", bringInNextSetofInput); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (bringInNextSetofInput !== 1'b0 || output_activation_stb !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ack_single_pulse: cycle %0d pulse=%b stb=%b required 0/0", i, bringInNextSetofInput, output_activation_stb);
      end
    end
  endtask

  task automatic test_zero_theta();
    logic [31:0] res;
    int p;
    for (int i = 0; i < N; i++) begin
      set_theta[i] = 32'd0;
      set_x[i] = {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)), 23'($urandom)};
    end
    run_set(0, res, p);
    vectors++;
    if (res !== 32'h3F000000) begin miscompares++; $display("[TB] FAIL zero_theta: got %h required 3F000000", res); end
    release_result();
  endtask

  // S = -3 gives c = -0.75, so A = 0.25/2 = 0.125.
  task automatic test_negative();
    logic [31:0] res;
    int p;
    for (int i = 0; i < N; i++) begin
      set_theta[i] = 32'h3F800000;
      set_x[i] = 32'hBF800000;
    end
    run_set(0, res, p);
    vectors++;
    if (res !== 32'h3E000000) begin miscompares++; $display("[TB] FAIL negative_sum: got %h required 3E000000", res); end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int p, diff;
    int guard = 0;
    load_reference();
    input_theta = set_theta[0]; input_x = set_x[0];
    input_theta_stb = 1'b1; input_x_stb = 1'b1;
    step();
    while (!bringInNextSetofInput && guard < 100) begin step(); guard++; end
    vectors++;
    if (!bringInNextSetofInput) begin miscompares++; $display("[TB] FAIL reset_mid_pulse: got 0 required 1 within 100 cycles"); end
    input_theta = set_theta[1]; input_x = set_x[1];
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (activation !== 32'd0 || output_activation_stb !== 1'b0 || bringInNextSetofInput !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_outputs: act=%h stb=%b pulse=%b required 00000000/0/0", activation, output_activation_stb, bringInNextSetofInput);
    end
    input_theta_stb = 1'b0; input_x_stb = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    run_set(0, res, p);
    diff = int'(res) - int'(REF_ACT);
    vectors++;
    if (diff > 2 || diff < -2) begin miscompares++; $display("[TB] FAIL reset_mid_rerun: got %h required %h +-2 ULP", res, REF_ACT); end
    release_result();
  endtask

  task automatic test_stall();
    logic [31:0] res;
    int p, diff;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (bringInNextSetofInput || output_activation_stb) begin
        miscompares++;
        $display("[TB] FAIL idle_get: pulse=%b stb=%b required 0/0", bringInNextSetofInput, output_activation_stb);
      end
    end
    load_reference();
    run_set(20, res, p);
    diff = int'(res) - int'(REF_ACT);
    vectors++;
    if (diff > 2 || diff < -2) begin miscompares++; $display("[TB] FAIL stall_result: got %h required %h +-2 ULP", res, REF_ACT); end
    release_result();
  endtask

  // Positive operands keep A in [0.5,1), where 2 ULP is 2^-23.
  task automatic test_random();
    logic [31:0] res;
    int p;
    real expv, err;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        set_theta[i] = {1'b0, 8'($urandom_range(122, 129)), 23'($urandom)};
        set_x[i] = {1'b0, 8'($urandom_range(122, 129)), 23'($urandom)};
      end
      expv = model_act();
      run_set(0, res, p);
      err = f2r(res) - expv;
      if (err < 0.0) err = -err;
      vectors++;
      if (err > 1.0 / 8388608.0) begin
        miscompares++;
        $display("[TB] FAIL random_set%0d: got %h (%f) required %f +-2 ULP", t, res, f2r(res), expv);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_hold_ack();
    test_zero_theta();
    test_negative();
    test_reset_mid();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
